// File: rtl/spim_reg_master.sv
// spim_reg_master: SPI register-access master (mode 0, MSB first).
// A host request launches one chip-select frame carrying a command byte,
// the address, write data or read data, and optional dummy bytes.
// Optional build macro SPIM_RD_CMP_EN adds read-data compare ports
// (cmp_en, exp_data, cmp_err, err_cnt).
`timescale 1ns/1ps

module spim_reg_master #(
   parameter int         AW          = 32,
   parameter int         DW          = 32,
   parameter int         CLK_DIV     = 2,
   parameter int         CS_GAP      = 4,
   parameter int         DUMMY_BYTES = 1,
   parameter logic [7:0] RD_CMD      = 8'h10,
   parameter logic [7:0] WR_CMD      = 8'h2F
) (
   input  logic          mclk,
   input  logic          reset,
   input  logic          req,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [DW-1:0] wdata,
   output logic [DW-1:0] rdata,
   output logic          ack,
   output logic          busy,
   output logic          spi_clk,
   output logic          spi_sel_n,
   output logic          spi_din,
   input  logic          spi_dout
`ifdef SPIM_RD_CMP_EN
   ,
   input  logic          cmp_en,
   input  logic [DW-1:0] exp_data,
   output logic          cmp_err,
   output logic [15:0]   err_cnt
`endif
);

   // Both frame kinds carry the same number of bits: a read simply
   // shifts out zeros while the slave returns data.
   localparam int NBITS = 8 + AW + DW + 8 * DUMMY_BYTES;
   localparam int BCW   = $clog2(8 + AW + DW + 32) + 1;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_SETUP = 3'd1;
   localparam logic [2:0] ST_SHIFT = 3'd2;
   localparam logic [2:0] ST_HOLD  = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;

   localparam logic [15:0]    GAP_LAST = 16'(CS_GAP - 1);
   localparam logic [15:0]    DIV_LAST = 16'(CLK_DIV - 1);
   localparam logic [15:0]    CNT_ONE  = 16'd1;
   localparam logic [BCW-1:0] BIT_LAST = BCW'(NBITS - 1);
   localparam logic [BCW-1:0] BIT_ONE  = BCW'(1);

   logic [2:0]       state_q, state_d;
   logic [15:0]      gap_q, gap_d;
   logic [15:0]      div_q, div_d;
   logic [BCW-1:0]   bit_q, bit_d;
   logic [NBITS-1:0] tx_q, tx_d;
   logic [DW-1:0]    rx_q, rx_d;
   logic             rd_q, rd_d;
   logic             sclk_q, sclk_d;
   logic             sel_n_q, sel_n_d;
   logic             din_q, din_d;
   logic             ack_q, ack_d;
   logic             busy_q, busy_d;
   logic [DW-1:0]    rdata_q, rdata_d;
   logic [NBITS-1:0] tx_load;

   // Frame image as it will appear on MOSI, MSB first.
   always_comb begin
      tx_load = '0;
      tx_load[NBITS-1 -: 8] = we ? WR_CMD : RD_CMD;
      tx_load[NBITS-9 -: AW] = addr;
      if (we) begin
         tx_load[NBITS-9-AW -: DW] = wdata;
      end
   end

   // Frame sequencer: CS setup, bit shifting with SCLK phases, CS hold, ack.
   always_comb begin
      state_d = state_q;
      gap_d   = gap_q;
      div_d   = div_q;
      bit_d   = bit_q;
      tx_d    = tx_q;
      rx_d    = rx_q;
      rd_d    = rd_q;
      sclk_d  = sclk_q;
      sel_n_d = sel_n_q;
      din_d   = din_q;
      ack_d   = 1'b0;
      busy_d  = busy_q;
      rdata_d = rdata_q;
      case (state_q)
         ST_IDLE: begin
            if (req) begin
               state_d = ST_SETUP;
               sel_n_d = 1'b0;
               busy_d  = 1'b1;
               gap_d   = '0;
               tx_d    = tx_load;
               rd_d    = ~we;
               rx_d    = '0;
            end
         end
         ST_SETUP: begin
            if (gap_q == GAP_LAST) begin
               // First bit goes out with SCLK still low.
               state_d = ST_SHIFT;
               din_d   = tx_q[NBITS-1];
               tx_d    = {tx_q[NBITS-2:0], 1'b0};
               div_d   = '0;
               bit_d   = '0;
            end else begin
               gap_d = gap_q + CNT_ONE;
            end
         end
         ST_SHIFT: begin
            if (div_q != DIV_LAST) begin
               div_d = div_q + CNT_ONE;
            end else begin
               div_d = '0;
               if (!sclk_q) begin
                  // Rising SCLK edge: capture MISO on the same mclk edge.
                  sclk_d = 1'b1;
                  rx_d   = {rx_q[DW-2:0], spi_dout};
               end else begin
                  // Falling SCLK edge: present the next bit while low.
                  sclk_d = 1'b0;
                  if (bit_q == BIT_LAST) begin
                     state_d = ST_HOLD;
                     din_d   = 1'b0;
                     gap_d   = '0;
                  end else begin
                     bit_d = bit_q + BIT_ONE;
                     din_d = tx_q[NBITS-1];
                     tx_d  = {tx_q[NBITS-2:0], 1'b0};
                  end
               end
            end
         end
         ST_HOLD: begin
            if (gap_q == GAP_LAST) begin
               // Read data is complete: the last DW samples are the word.
               state_d = ST_DONE;
               sel_n_d = 1'b1;
               ack_d   = 1'b1;
               if (rd_q) begin
                  rdata_d = rx_q;
               end
            end else begin
               gap_d = gap_q + CNT_ONE;
            end
         end
         ST_DONE: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State registers with synchronous reset; reset drops any partial frame.
   always_ff @(posedge mclk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         gap_q   <= '0;
         div_q   <= '0;
         bit_q   <= '0;
         tx_q    <= '0;
         rx_q    <= '0;
         rd_q    <= 1'b0;
         sclk_q  <= 1'b0;
         sel_n_q <= 1'b1;
         din_q   <= 1'b0;
         ack_q   <= 1'b0;
         busy_q  <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         gap_q   <= gap_d;
         div_q   <= div_d;
         bit_q   <= bit_d;
         tx_q    <= tx_d;
         rx_q    <= rx_d;
         rd_q    <= rd_d;
         sclk_q  <= sclk_d;
         sel_n_q <= sel_n_d;
         din_q   <= din_d;
         ack_q   <= ack_d;
         busy_q  <= busy_d;
         rdata_q <= rdata_d;
      end
   end

   assign rdata     = rdata_q;
   assign ack       = ack_q;
   assign busy      = busy_q;
   assign spi_clk   = sclk_q;
   assign spi_sel_n = sel_n_q;
   assign spi_din   = din_q;

`ifdef SPIM_RD_CMP_EN
   logic          cmp_en_q, cmp_en_d;
   logic [DW-1:0] exp_q, exp_d;
   logic          cmp_err_q, cmp_err_d;
   logic [15:0]   err_cnt_q, err_cnt_d;

   // Compare latched expectation against the finished read word at ack time.
   always_comb begin
      cmp_en_d  = cmp_en_q;
      exp_d     = exp_q;
      cmp_err_d = 1'b0;
      err_cnt_d = err_cnt_q;
      if (state_q == ST_IDLE && req) begin
         cmp_en_d = cmp_en;
         exp_d    = exp_data;
      end
      if (state_q == ST_HOLD && gap_q == GAP_LAST && rd_q && cmp_en_q &&
          rx_q != exp_q) begin
         cmp_err_d = 1'b1;
         if (err_cnt_q != 16'hFFFF) begin
            err_cnt_d = err_cnt_q + 16'd1;
         end
      end
   end

   // Compare registers; the error counter saturates and clears only on reset.
   always_ff @(posedge mclk) begin
      if (reset) begin
         cmp_en_q  <= 1'b0;
         exp_q     <= '0;
         cmp_err_q <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         cmp_en_q  <= cmp_en_d;
         exp_q     <= exp_d;
         cmp_err_q <= cmp_err_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign cmp_err = cmp_err_q;
   assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_spim_reg_master.sv
// Testbench for spim_reg_master: table vectors, random transactions against
// a frame-level reference model, and hand-written multi-cycle sequences.
`timescale 1ns/1ps

module tb_spim_reg_master;

   // Instance A: default parameters.
   localparam int AW = 32, DW = 32, CD = 2, CG = 4, DB = 1;
   localparam int NA = 8 + AW + DW + 8 * DB;
   localparam int LAT_A = 1 + CG + 2 * CD * NA + CG + 1;
   localparam int RSTART_A = 8 + AW + 8 * DB;
   // Instance B: narrow, fast, no dummy bytes.
   localparam int BAW = 24, BDW = 16, BCD = 1, BCG = 2;
   localparam int NB = 8 + BAW + BDW;
   localparam int LAT_B = 1 + BCG + 2 * BCD * NB + BCG + 1;
   localparam int RSTART_B = 8 + BAW;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic          rst_a = 1'b1, req_a = 1'b0, we_a = 1'b0;
   logic [31:0]   addr_a = '0, wdata_a = '0, rdata_a;
   logic          ack_a, busy_a, sclk_a, seln_a, din_a, dout_a = 1'b0;
`ifdef SPIM_RD_CMP_EN
   logic          cmp_en_a = 1'b0;
   logic [31:0]   exp_a = '0;
   logic          cmp_err_a;
   logic [15:0]   err_cnt_a;
   logic          last_cmp_err = 1'b0;
`endif

   logic          rst_b = 1'b1, req_b = 1'b0, we_b = 1'b0;
   logic [23:0]   addr_b = '0;
   logic [15:0]   wdata_b = '0, rdata_b;
   logic          ack_b, busy_b, sclk_b, seln_b, din_b, dout_b = 1'b0;

   spim_reg_master dut_a (
      .mclk(clk), .reset(rst_a), .req(req_a), .we(we_a), .addr(addr_a),
      .wdata(wdata_a), .rdata(rdata_a), .ack(ack_a), .busy(busy_a),
      .spi_clk(sclk_a), .spi_sel_n(seln_a), .spi_din(din_a), .spi_dout(dout_a)
`ifdef SPIM_RD_CMP_EN
      , .cmp_en(cmp_en_a), .exp_data(exp_a), .cmp_err(cmp_err_a), .err_cnt(err_cnt_a)
`endif
   );

   spim_reg_master #(.AW(BAW), .DW(BDW), .CLK_DIV(BCD), .CS_GAP(BCG), .DUMMY_BYTES(0)) dut_b (
      .mclk(clk), .reset(rst_b), .req(req_b), .we(we_b), .addr(addr_b),
      .wdata(wdata_b), .rdata(rdata_b), .ack(ack_b), .busy(busy_b),
      .spi_clk(sclk_b), .spi_sel_n(seln_b), .spi_din(din_b), .spi_dout(dout_b)
   );

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // ---------------- slave model / monitor for instance A ----------------
   logic        psclk_a = 1'b0, pseln_a = 1'b1;
   int          rises_a = 0, sel_rise_cyc_a = 0, first_gap_a = 0;
   logic [127:0] cap_a = '0;
   logic [31:0] slave_a = '0;

   // Read word occupies the bit slots after command, address and dummy bytes;
   // every other slot gets a random junk bit the master must ignore.
   function automatic logic sbit_a(int i);
      if (i >= RSTART_A && i < RSTART_A + DW) return slave_a[DW-1-(i-RSTART_A)];
      return 1'($urandom() & 1);
   endfunction

   always @(posedge clk) begin
      #1;
      if (pseln_a && !seln_a) begin
         rises_a = 0; cap_a = '0; first_gap_a = -1; dout_a = sbit_a(0);
      end
      if (!pseln_a && seln_a) sel_rise_cyc_a = cyc;
      if (!psclk_a && sclk_a) begin
         cap_a = {cap_a[126:0], din_a};
         if (rises_a == 0) first_gap_a = cyc - sel_rise_cyc_a;
         rises_a++;
      end
      if (psclk_a && !sclk_a) dout_a = sbit_a(rises_a);
      psclk_a = sclk_a;
      pseln_a = seln_a;
   end

   // ---------------- slave model / monitor for instance B ----------------
   logic        psclk_b = 1'b0, pseln_b = 1'b1;
   int          rises_b = 0, last_rise_b = 0, pmin_b = 0, pmax_b = 0;
   logic [127:0] cap_b = '0;
   logic [15:0] slave_b = '0;

   function automatic logic sbit_b(int i);
      if (i >= RSTART_B && i < RSTART_B + BDW) return slave_b[BDW-1-(i-RSTART_B)];
      return 1'($urandom() & 1);
   endfunction

   always @(posedge clk) begin
      #1;
      if (pseln_b && !seln_b) begin
         rises_b = 0; cap_b = '0; pmin_b = 1000; pmax_b = 0; dout_b = sbit_b(0);
      end
      if (!psclk_b && sclk_b) begin
         cap_b = {cap_b[126:0], din_b};
         if (rises_b > 0) begin
            if (cyc - last_rise_b < pmin_b) pmin_b = cyc - last_rise_b;
            if (cyc - last_rise_b > pmax_b) pmax_b = cyc - last_rise_b;
         end
         last_rise_b = cyc;
         rises_b++;
      end
      if (psclk_b && !sclk_b) dout_b = sbit_b(rises_b);
      psclk_b = sclk_b;
      pseln_b = seln_b;
   end

   // Reference model: MOSI image of a frame and rdata retention.
   logic [31:0] rd_model = '0;

   function automatic logic [79:0] mosi_model(bit w, logic [31:0] a, logic [31:0] d);
      if (w) return {8'h2F, a, d, 8'h00};
      return {8'h10, a, 8'h00, 32'h0};
   endfunction

   // One complete frame on instance A, checked end to end.
   task automatic run_a(input string tag, input bit w, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] slv,
                        input logic [79:0] exp_mosi, input logic [31:0] exp_rd,
                        input bit hold_req, input bit pulse_mid);
      int  cnt;
      bit  got;
      bit  sel_bad;
      slave_a = slv; we_a = w; addr_a = a; wdata_a = d; req_a = 1'b1;
      @(posedge clk); #1;
      cnt = 2;
      if (!hold_req) req_a = 1'b0;
      we_a = ~w; addr_a = $urandom(); wdata_a = $urandom();
      check({tag, " accept"}, {126'b0, busy_a, seln_a}, 128'b10);
      got = 1'b0; sel_bad = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(posedge clk); #1;
         cnt++;
         if (pulse_mid && cnt == 100) req_a = 1'b1;
         if (pulse_mid && cnt == 101) req_a = 1'b0;
         if (ack_a) begin got = 1'b1; break; end
         if (seln_a || !busy_a) sel_bad = 1'b1;
      end
      check({tag, " ack_seen"}, 128'(got), 128'd1);
      check({tag, " latency"}, 128'(cnt), 128'(LAT_A));
      check({tag, " rdata"}, 128'(rdata_a), 128'(exp_rd));
      check({tag, " mosi"}, cap_a, 128'(exp_mosi));
      check({tag, " sclk_rises"}, 128'(rises_a), 128'(NA));
      check({tag, " cs_low_busy"}, 128'(sel_bad), 128'd0);
      check({tag, " done_cs_busy"}, {126'b0, seln_a, busy_a}, 128'b11);
`ifdef SPIM_RD_CMP_EN
      last_cmp_err = cmp_err_a;
`endif
      @(posedge clk); #1;
      check({tag, " after_ack"}, {125'b0, ack_a, busy_a, seln_a}, 128'b001);
      check({tag, " rdata_held"}, 128'(rdata_a), 128'(exp_rd));
      rd_model = exp_rd;
      $display("txn %s we=%0d addr=%h wdata=%h rdata=%h latency=%0d rises=%0d",
               tag, w, a, d, rdata_a, cnt, rises_a);
   endtask

   typedef struct {
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] slave;
      logic [31:0] exp_rd;
      logic [79:0] exp_mosi;
   } vec_t;

   vec_t vecs[4];

   initial begin
      int cnt;
      bit got;
      int acks;
      bit bad;
      vecs[0] = '{1'b1, 32'h1002_0004, 32'hA5A5_5A5A, 32'h1357_9BDF, 32'h0000_0000,
                  80'h2F_10020004_A5A55A5A_00};
      vecs[1] = '{1'b0, 32'h3000_0000, 32'h0F0F_0F0F, 32'hDEAD_BEEF, 32'hDEAD_BEEF,
                  80'h10_30000000_00_00000000};
      vecs[2] = '{1'b1, 32'h0000_00FF, 32'h0123_4567, 32'hFFFF_FFFF, 32'hDEAD_BEEF,
                  80'h2F_000000FF_01234567_00};
      vecs[3] = '{1'b0, 32'hFFFF_FFFC, 32'h0, 32'h8000_0001, 32'h8000_0001,
                  80'h10_FFFFFFFC_00_00000000};

      // Reset state of both instances.
      repeat (3) @(posedge clk);
      #1;
      check("reset_a", {121'b0, sclk_a, seln_a, din_a, ack_a, busy_a, rdata_a != 0, 1'b0}, 128'b0100000);
      check("reset_b", {122'b0, sclk_b, seln_b, din_b, ack_b, busy_b, rdata_b != 0}, 128'b010000);
      rst_a = 1'b0; rst_b = 1'b0;
      @(posedge clk); #1;

      // Table vectors.
      for (int i = 0; i < 4; i++)
         run_a($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].wdata,
               vecs[i].slave, vecs[i].exp_mosi, vecs[i].exp_rd, 1'b0, 1'b0);

      // Random transactions against the model.
      for (int i = 0; i < 6; i++) begin
         bit          w;
         logic [31:0] a, d, s, er;
         w = 1'($urandom() & 1); a = $urandom(); d = $urandom(); s = $urandom();
         er = w ? rd_model : s;
         run_a($sformatf("rnd%0d", i), w, a, d, s, mosi_model(w, a, d), er, 1'b0, 1'b0);
      end

      // Reset after 20 SCLK rises of a write: frame dropped, no ack.
      we_a = 1'b1; addr_a = 32'hCAFE_0001; wdata_a = 32'h7777_8888; req_a = 1'b1;
      @(posedge clk); #1;
      req_a = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         if (rises_a >= 20) begin got = 1'b1; break; end
         @(posedge clk); #1;
      end
      check("rst_mid reached_20", 128'(got), 128'd1);
      rst_a = 1'b1;
      @(posedge clk); #1;
      check("rst_mid outputs", {123'b0, seln_a, sclk_a, busy_a, ack_a, din_a}, 128'b10000);
      check("rst_mid rdata", 128'(rdata_a), 128'd0);
      rst_a = 1'b0;
      acks = 0; bad = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(posedge clk); #1;
         if (ack_a) acks++;
         if (!seln_a || busy_a) bad = 1'b1;
      end
      check("rst_mid no_ack", 128'(acks), 128'd0);
      check("rst_mid stays_idle", 128'(bad), 128'd0);
      $display("txn rst_mid rises_before_reset=%0d acks_after=%0d", rises_a, acks);
      rd_model = '0;
      run_a("post_rst_read", 1'b0, 32'h0000_0040, 32'h0, 32'h600D_F00D,
            mosi_model(1'b0, 32'h0000_0040, 32'h0), 32'h600D_F00D, 1'b0, 1'b0);

      // req pulse while busy is ignored; no queued frame afterwards.
      run_a("pulse_busy", 1'b1, 32'h0000_1111, 32'h2222_3333, 32'h0,
            mosi_model(1'b1, 32'h0000_1111, 32'h2222_3333), rd_model, 1'b0, 1'b1);
      bad = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (!seln_a || busy_a) bad = 1'b1;
      end
      check("pulse_busy no_queue", 128'(bad), 128'd0);

      // req held through ack: back-to-back frames.
      run_a("hold1", 1'b0, 32'h0000_2000, 32'h0, 32'hAAAA_5555,
            mosi_model(1'b0, 32'h0000_2000, 32'h0), 32'hAAAA_5555, 1'b1, 1'b0);
      run_a("hold2", 1'b1, 32'h0000_2004, 32'h1234_5678, 32'h0,
            mosi_model(1'b1, 32'h0000_2004, 32'h1234_5678), 32'hAAAA_5555, 1'b0, 1'b0);
      checks++;
      if (first_gap_a < CG + 1) begin
         failures++;
         $display("FAIL hold cs_gap actual=%0d required>=%0d", first_gap_a, CG + 1);
      end
      $display("txn hold_gap cs_high_to_first_sclk=%0d", first_gap_a);

`ifdef SPIM_RD_CMP_EN
      cmp_en_a = 1'b1; exp_a = 32'h0;
      run_a("cmp_miss", 1'b0, 32'h0000_0100, 32'h0, 32'h0000_0001,
            mosi_model(1'b0, 32'h0000_0100, 32'h0), 32'h0000_0001, 1'b0, 1'b0);
      check("cmp_miss err", 128'(last_cmp_err), 128'd1);
      check("cmp_miss cnt", 128'(err_cnt_a), 128'd1);
      exp_a = 32'h0000_0055;
      run_a("cmp_hit", 1'b0, 32'h0000_0104, 32'h0, 32'h0000_0055,
            mosi_model(1'b0, 32'h0000_0104, 32'h0), 32'h0000_0055, 1'b0, 1'b0);
      check("cmp_hit err", 128'(last_cmp_err), 128'd0);
      check("cmp_hit cnt", 128'(err_cnt_a), 128'd1);
`endif

      // Instance B: AW=24, DW=16, CLK_DIV=1, no dummy bytes.
      slave_b = 16'h1234; we_b = 1'b0; addr_b = 24'h00_0010; wdata_b = 16'hFFFF; req_b = 1'b1;
      @(posedge clk); #1;
      req_b = 1'b0;
      cnt = 2; got = 1'b0;
      for (int i = 0; i < 500; i++) begin
         @(posedge clk); #1;
         cnt++;
         if (ack_b) begin got = 1'b1; break; end
      end
      check("b_read ack_seen", 128'(got), 128'd1);
      check("b_read latency", 128'(cnt), 128'(LAT_B));
      check("b_read rdata", 128'(rdata_b), 128'h1234);
      check("b_read rises", 128'(rises_b), 128'(NB));
      check("b_read mosi", cap_b, 128'h10_000010_0000);
      check("b_read period_min", 128'(pmin_b), 128'd2);
      check("b_read period_max", 128'(pmax_b), 128'd2);
      $display("txn b_read addr=%h rdata=%h latency=%0d rises=%0d period=%0d..%0d",
               addr_b, rdata_b, cnt, rises_b, pmin_b, pmax_b);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
